// File: rtl/cyclic_prefix_removal_if.sv
// Valid/ready IQ sample stream: 32-bit {Q[31:16], I[15:0]} data plus a last flag.
interface cyclic_prefix_removal_if;
  logic        valid;
  logic        ready;
  logic [31:0] data;
  logic        last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/cyclic_prefix_removal.sv
// Strips the cyclic prefix from each OFDM symbol after the preamble marker; FFT_LEN-sample bodies out.
// One output register (1-cycle latency); input stalls only in BODY while the output register is held.
module cyclic_prefix_removal #(
  parameter int unsigned FFT_LEN = 64,
  parameter int unsigned CP_LEN  = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [15:0]             symbols,
  cyclic_prefix_removal_if.slave  s,
  cyclic_prefix_removal_if.master m,
  output logic                    trunc,
  output logic                    busy
);

  typedef enum logic [1:0] {SEARCH, CP, BODY} state_t;

  localparam logic [15:0] BODY_LAST = 16'(FFT_LEN - 1);
  localparam logic [15:0] CP_LAST   = 16'(CP_LEN - 1);
  localparam bit          NO_CP     = (CP_LEN == 0);

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  state_t      state;
  logic [15:0] cp_cnt;
  logic [15:0] body_cnt;
  logic [15:0] sym_cnt;
  logic [15:0] sym_lim;
  logic        acc;

  assign s.ready = (state != BODY) || !m.valid || m.ready;
  assign acc     = s.valid && s.ready;
  assign trunc   = (state == BODY) && acc && s.last && (body_cnt != BODY_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SEARCH;
      cp_cnt   <= '0;
      body_cnt <= '0;
      sym_cnt  <= '0;
      sym_lim  <= '0;
      busy     <= 1'b0;
      m.valid  <= 1'b0;
      m.last   <= 1'b0;
      m.data   <= '0;
    end else begin
      if (m.ready) m.valid <= 1'b0;
      case (state)
        SEARCH: begin
          if (acc && s.last) begin
            sym_cnt  <= '0;
            cp_cnt   <= '0;
            body_cnt <= '0;
            sym_lim  <= symbols;
            busy     <= 1'b1;
            state    <= NO_CP ? BODY : CP;
          end
        end
        CP: begin
          if (acc) begin
            if (s.last) begin
              cp_cnt  <= '0;
              sym_cnt <= '0;
              sym_lim <= symbols;
            end else if (cp_cnt == CP_LAST) begin
              cp_cnt   <= '0;
              body_cnt <= '0;
              state    <= BODY;
            end else begin
              cp_cnt <= cp_cnt + 16'd1;
            end
          end
        end
        BODY: begin
          if (acc) begin
            m.valid <= 1'b1;
            m.data  <= s.data;
            if (s.last) begin
              // Resync: realign on the new marker regardless of the symbol limit.
              m.last   <= 1'b1;
              cp_cnt   <= '0;
              body_cnt <= '0;
              sym_cnt  <= '0;
              sym_lim  <= symbols;
              state    <= NO_CP ? BODY : CP;
            end else if (body_cnt == BODY_LAST) begin
              m.last   <= 1'b1;
              body_cnt <= '0;
              cp_cnt   <= '0;
              sym_cnt  <= sym_cnt + 16'd1;
              if (sym_lim != 16'd0 && (sym_cnt + 16'd1) == sym_lim) begin
                state <= SEARCH;
                busy  <= 1'b0;
              end else begin
                state <= NO_CP ? BODY : CP;
              end
            end else begin
              m.last   <= 1'b0;
              body_cnt <= body_cnt + 16'd1;
            end
          end
        end
        default: begin
          state <= SEARCH;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cyclic_prefix_removal.sv
// Directed bench for cyclic_prefix_removal: CP_LEN=16 and CP_LEN=0 instances share one stimulus driver.
`timescale 1ns/1ps
module tb_cyclic_prefix_removal;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] symbols = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic [31:0] s_data = '0;
  logic        m_ready = 1'b1;
  logic        sel = 1'b0;
  int          rdy_mode = 0;

  int n_checks = 0;
  int n_err = 0;
  int trunc_cnt = 0;

  logic [32:0] cap[$];
  logic [32:0] exp_q[$];

  cyclic_prefix_removal_if sa();
  cyclic_prefix_removal_if ma();
  cyclic_prefix_removal_if sb();
  cyclic_prefix_removal_if mb();

  logic trunc_a, busy_a, trunc_b, busy_b;

  assign sa.valid = s_valid;
  assign sa.data  = s_data;
  assign sa.last  = s_last;
  assign sb.valid = s_valid;
  assign sb.data  = s_data;
  assign sb.last  = s_last;
  assign ma.ready = m_ready;
  assign mb.ready = m_ready;

  cyclic_prefix_removal #(.FFT_LEN(64), .CP_LEN(16)) dut_a (
    .clk(clk), .resetn(resetn), .symbols(symbols),
    .s(sa), .m(ma), .trunc(trunc_a), .busy(busy_a)
  );

  cyclic_prefix_removal #(.FFT_LEN(64), .CP_LEN(0)) dut_b (
    .clk(clk), .resetn(resetn), .symbols(symbols),
    .s(sb), .m(mb), .trunc(trunc_b), .busy(busy_b)
  );

  logic        cur_s_ready, cur_m_valid, cur_m_last, cur_trunc, cur_busy;
  logic [31:0] cur_m_data;

  assign cur_s_ready = sel ? sb.ready : sa.ready;
  assign cur_m_valid = sel ? mb.valid : ma.valid;
  assign cur_m_last  = sel ? mb.last  : ma.last;
  assign cur_m_data  = sel ? mb.data  : ma.data;
  assign cur_trunc   = sel ? trunc_b  : trunc_a;
  assign cur_busy    = sel ? busy_b   : busy_a;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
  end

  // Output monitor: captures transfers, counts trunc cycles, checks hold stability.
  logic        prev_hold = 1'b0;
  logic [32:0] prev_word = '0;

  always @(negedge clk) begin
    if (!resetn) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_vld", 64'(cur_m_valid), 64'd1);
        check("hold_dat", 64'({cur_m_last, cur_m_data}), 64'(prev_word));
      end
      if (cur_m_valid && m_ready) cap.push_back({cur_m_last, cur_m_data});
      if (cur_trunc) trunc_cnt++;
      prev_hold = cur_m_valid && !m_ready;
      prev_word = {cur_m_last, cur_m_data};
    end
  end

  task automatic do_reset();
    resetn  = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    cap.delete();
    exp_q.delete();
    trunc_cnt = 0;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!acc && n < 500) begin
      @(negedge clk);
      acc = cur_s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("send_acc", 64'(acc), 64'd1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Junk preamble, marker, then n samples carrying their index; s_last on index last_at.
  task automatic frame(input int junk, input int n, input int last_at);
    for (int i = 0; i < junk; i++) send(32'hDEAD_0000 + 32'(i), 1'b0);
    send(32'hDEAD_FFFF, 1'b1);
    for (int i = 0; i < n; i++) send(32'(i), 1'(i == last_at));
  endtask

  task automatic add_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_q.push_back({1'(i == hi), 32'(i)});
  endtask

  task automatic wait_out(input int n);
    for (int i = 0; i < 3000 && cap.size() < n; i++) @(negedge clk);
    repeat (5) @(negedge clk);
  endtask

  task automatic compare(input string tag);
    check({tag, "_len"}, 64'(cap.size()), 64'(exp_q.size()));
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
      check({tag, "_smp"}, 64'(cap[i]), 64'(exp_q[i]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lasts;

    do_reset();
    @(negedge clk);
    check("rst_m_valid", 64'(cur_m_valid), 64'd0);
    check("rst_m_last",  64'(cur_m_last),  64'd0);
    check("rst_m_data",  64'(cur_m_data),  64'd0);
    check("rst_busy",    64'(cur_busy),    64'd0);
    check("rst_trunc",   64'(cur_trunc),   64'd0);
    check("rst_s_ready", 64'(cur_s_ready), 64'd1);
    @(posedge clk);
    #1;

    // Basic alignment, two symbols then back to SEARCH
    symbols = 16'd2;
    frame(10, 160, -1);
    add_range(16, 79);
    add_range(96, 159);
    wait_out(128);
    compare("basic");
    check("basic_trunc", 64'(trunc_cnt), 64'd0);
    check("basic_busy",  64'(cur_busy),  64'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) send(32'hBEEF_0000 + 32'(i), 1'b0);
    repeat (5) @(negedge clk);
    check("basic_drop", 64'(cap.size()), 64'd128);

    // Backpressure
    do_reset();
    rdy_mode = 1;
    symbols  = 16'd2;
    frame(10, 160, -1);
    add_range(16, 79);
    add_range(96, 159);
    wait_out(128);
    compare("bp");
    check("bp_trunc", 64'(trunc_cnt), 64'd0);
    rdy_mode = 0;

    // Unlimited frame
    do_reset();
    symbols = 16'd0;
    frame(3, 800, -1);
    for (int k = 0; k < 10; k++) add_range(k * 80 + 16, k * 80 + 79);
    wait_out(640);
    compare("unlim");
    lasts = 0;
    foreach (cap[i]) if (cap[i][32]) lasts++;
    check("unlim_lasts", 64'(lasts), 64'd10);
    check("unlim_busy",  64'(cur_busy), 64'd1);

    // Truncation on body index 30 of symbol 0
    do_reset();
    symbols = 16'd1;
    frame(5, 127, 46);
    add_range(16, 46);
    add_range(63, 126);
    wait_out(95);
    compare("trunc");
    check("trunc_pulses", 64'(trunc_cnt), 64'd1);
    check("trunc_busy",   64'(cur_busy),  64'd0);

    // CP_LEN = 0 instance
    sel = 1'b1;
    do_reset();
    symbols = 16'd3;
    frame(4, 192, -1);
    add_range(0, 63);
    add_range(64, 127);
    add_range(128, 191);
    wait_out(192);
    compare("nocp");
    check("nocp_busy",  64'(cur_busy),  64'd0);
    check("nocp_trunc", 64'(trunc_cnt), 64'd0);

    // Reset with an output sample pending
    sel = 1'b0;
    do_reset();
    rdy_mode = 2;
    symbols  = 16'd0;
    @(posedge clk);
    #1;
    frame(2, 17, -1);
    @(negedge clk);
    check("rstmid_pre_vld", 64'(cur_m_valid), 64'd1);
    #2 resetn = 1'b0;
    #1;
    check("rstmid_vld",  64'(cur_m_valid), 64'd0);
    check("rstmid_data", 64'(cur_m_data),  64'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    rdy_mode = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rstmid_busy",    64'(cur_busy),    64'd0);
    check("rstmid_s_ready", 64'(cur_s_ready), 64'd1);
    check("rstmid_vld2",    64'(cur_m_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
